sram_controller: RTL and testbench



---
 rtl/sram_controller.sv | 129 ++++++++++++
 tb/tb_sram_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Sequences 32-bit load/store requests onto a 16-bit asynchronous SRAM as two
// half-word accesses, each lasting WAIT_CYCLES clocks, and stalls the pipeline meanwhile.
module sram_controller #(
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  input  logic [15:0] sramDqIn,
  output logic        sramDqOe,
  output logic        sramWeN
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0]  LAST     = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0]  PRE_LAST = 4'(WAIT_CYCLES - 2);
  localparam logic        WE_FIRST = (WAIT_CYCLES == 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] word;
  logic [15:0] wdata_hi;
  logic [15:0] lo_q;
  logic [31:0] off;
  logic        last;
  logic        unused_bits;

  assign off         = address - BASE;
  assign unused_bits = ^{off[31:19], off[1:0]};
  assign last        = (cnt == LAST);
  assign ready       = (state == DONE) || (state == IDLE && !rdEn && !wrEn);

  // Outputs are registered, so each transition loads the pin values for the
  // first cycle of the state being entered; WE rises one cycle before a write phase ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      wdata_hi  <= '0;
      lo_q      <= '0;
      readData  <= '0;
      sramAddr  <= '0;
      sramDqOut <= '0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wrEn) begin
            word      <= off[18:2];
            wdata_hi  <= writeData[31:16];
            sramAddr  <= {off[18:2], 1'b0};
            sramDqOut <= writeData[15:0];
            sramDqOe  <= 1'b1;
            sramWeN   <= WE_FIRST;
            state     <= WR_LO;
          end else if (rdEn) begin
            word     <= off[18:2];
            sramAddr <= {off[18:2], 1'b0};
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          if (last) begin
            lo_q     <= sramDqIn;
            cnt      <= '0;
            sramAddr <= {word, 1'b1};
            state    <= RD_HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (last) begin
            readData <= {sramDqIn, lo_q};
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_LO: begin
          if (last) begin
            cnt       <= '0;
            sramAddr  <= {word, 1'b1};
            sramDqOut <= wdata_hi;
            sramWeN   <= WE_FIRST;
            state     <= WR_HI;
          end else begin
            cnt     <= cnt + 4'd1;
            sramWeN <= (cnt == PRE_LAST);
          end
        end
        WR_HI: begin
          if (last) begin
            cnt      <= '0;
            sramDqOe <= 1'b0;
            sramWeN  <= 1'b1;
            state    <= DONE;
          end else begin
            cnt     <= cnt + 4'd1;
            sramWeN <= (cnt == PRE_LAST);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          sramDqOe <= 1'b0;
          sramWeN  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a WAIT_CYCLES=4 instance and a
// WAIT_CYCLES=1 instance share stimulus, each backed by a small SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] address;
  logic [31:0] writeData;

  logic [31:0] rd4, rd1;
  logic        ready4, ready1;
  logic [17:0] addr4, addr1;
  logic [15:0] dqo4, dqo1, dqi4, dqi1;
  logic        oe4, oe1, we4, we1;

  logic [15:0] mem4 [0:63];
  logic [15:0] mem1 [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(4), .BASE_ADDR(1024)) u_dut4 (
    .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
    .writeData(writeData), .readData(rd4), .ready(ready4), .sramAddr(addr4),
    .sramDqOut(dqo4), .sramDqIn(dqi4), .sramDqOe(oe4), .sramWeN(we4)
  );

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) u_dut1 (
    .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
    .writeData(writeData), .readData(rd1), .ready(ready1), .sramAddr(addr1),
    .sramDqOut(dqo1), .sramDqIn(dqi1), .sramDqOe(oe1), .sramWeN(we1)
  );

  // SRAM models: data driven onto the bus lands in the addressed cell.
  assign dqi4 = mem4[addr4[5:0]];
  assign dqi1 = mem1[addr1[5:0]];

  always @(posedge clk) begin
    if (oe4) mem4[addr4[5:0]] <= dqo4;
    if (oe1) mem1[addr1[5:0]] <= dqo1;
  end

  task test_reset;
    rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++; if (ready4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", ready4); end
    checks++; if (rd4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_readData got %h expected 0", rd4); end
    checks++; if (addr4 !== 18'h0) begin errors++; $display("[TB] FAIL reset_sramAddr got %h expected 0", addr4); end
    checks++; if (dqo4 !== 16'h0) begin errors++; $display("[TB] FAIL reset_dqOut got %h expected 0", dqo4); end
    checks++; if (we4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_weN got %b expected 1", we4); end
    checks++; if (oe4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe got %b expected 0", oe4); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_w1 got %b expected 1", ready1); end
  endtask

  task test_write;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    @(negedge clk);
    wrEn = 1'b1; address = 32'd1024; writeData = 32'hDEADBEEF;
    #1;
    checks++; if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL write_ready_c0 got %b expected 0", ready4); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      wrEn = 1'b0;
      checks++; if (ready4 !== (k == 9)) begin errors++; $display("[TB] FAIL write_ready_c%0d got %b expected %b", k, ready4, (k == 9)); end
      if (k <= 8) begin
        exp_addr = (k <= 4) ? 18'd0 : 18'd1;
        exp_dq   = (k <= 4) ? 16'hBEEF : 16'hDEAD;
        checks++; if (addr4 !== exp_addr) begin errors++; $display("[TB] FAIL write_addr_c%0d got %h expected %h", k, addr4, exp_addr); end
        checks++; if (dqo4 !== exp_dq) begin errors++; $display("[TB] FAIL write_dq_c%0d got %h expected %h", k, dqo4, exp_dq); end
        checks++; if (oe4 !== 1'b1) begin errors++; $display("[TB] FAIL write_oe_c%0d got %b expected 1", k, oe4); end
        checks++; if (we4 !== (k == 4 || k == 8)) begin errors++; $display("[TB] FAIL write_weN_c%0d got %b expected %b", k, we4, (k == 4 || k == 8)); end
      end else begin
        checks++; if (oe4 !== 1'b0 || we4 !== 1'b1) begin errors++; $display("[TB] FAIL write_done_pins got oe=%b weN=%b expected oe=0 weN=1", oe4, we4); end
      end
    end
  endtask

  task test_read(input logic [31:0] addr, input logic [31:0] prev);
    logic [17:0] exp_addr;
    @(negedge clk);
    rdEn = 1'b1; address = addr;
    #1;
    checks++; if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL read_ready_c0 got %b expected 0", ready4); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rdEn = 1'b0;
      checks++; if (oe4 !== 1'b0 || we4 !== 1'b1) begin errors++; $display("[TB] FAIL read_pins_c%0d got oe=%b weN=%b expected oe=0 weN=1", k, oe4, we4); end
      if (k <= 8) begin
        exp_addr = (k <= 4) ? 18'd0 : 18'd1;
        checks++; if (addr4 !== exp_addr) begin errors++; $display("[TB] FAIL read_addr_c%0d got %h expected %h", k, addr4, exp_addr); end
      end
      if (k == 8) begin
        checks++; if (rd4 !== prev) begin errors++; $display("[TB] FAIL read_data_early got %h expected %h", rd4, prev); end
      end
    end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("[TB] FAIL read_ready_done got %b expected 1", ready4); end
    checks++; if (rd4 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data got %h expected deadbeef", rd4); end
  endtask

  task test_write_priority;
    logic [17:0] exp_addr;
    @(negedge clk);
    rdEn = 1'b1; wrEn = 1'b1; address = 32'd1032; writeData = 32'h12345678;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rdEn = 1'b0; wrEn = 1'b0;
      if (k <= 8) begin
        exp_addr = (k <= 4) ? 18'd4 : 18'd5;
        checks++; if (addr4 !== exp_addr || oe4 !== 1'b1) begin errors++; $display("[TB] FAIL prio_addr_c%0d got %h oe=%b expected %h oe=1", k, addr4, oe4, exp_addr); end
      end
    end
    checks++; if (mem4[4] !== 16'h5678 || mem4[5] !== 16'h1234) begin errors++; $display("[TB] FAIL prio_mem got %h_%h expected 1234_5678", mem4[5], mem4[4]); end
    checks++; if (rd4 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL prio_readData got %h expected deadbeef", rd4); end
  endtask

  task test_reset_mid;
    @(negedge clk);
    rdEn = 1'b1; address = 32'd1024;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rdEn = 1'b0;
    end
    checks++; if (addr4 !== 18'd1) begin errors++; $display("[TB] FAIL midreset_in_hi got addr %h expected 1", addr4); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready4 !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got %b expected 1", ready4); end
    checks++; if (rd4 !== 32'h0) begin errors++; $display("[TB] FAIL midreset_readData got %h expected 0", rd4); end
    checks++; if (we4 !== 1'b1 || oe4 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pins got weN=%b oe=%b expected weN=1 oe=0", we4, oe4); end
    checks++; if (addr4 !== 18'd0) begin errors++; $display("[TB] FAIL midreset_addr got %h expected 0", addr4); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task test_back_to_back;
    @(negedge clk);
    wrEn = 1'b1; address = 32'd1028; writeData = 32'hCAFEF00D;
    #1;
    checks++; if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_c0 got %b expected 0", ready1); end
    @(negedge clk);
    wrEn = 1'b0;
    checks++; if (ready1 !== 1'b0 || addr1 !== 18'd2 || dqo1 !== 16'hF00D || oe1 !== 1'b1 || we1 !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_wr_lo got rdy=%b addr=%h dq=%h oe=%b weN=%b expected 0 2 f00d 1 1", ready1, addr1, dqo1, oe1, we1); end
    @(negedge clk);
    checks++; if (ready1 !== 1'b0 || addr1 !== 18'd3 || dqo1 !== 16'hCAFE)
      begin errors++; $display("[TB] FAIL b2b_wr_hi got rdy=%b addr=%h dq=%h expected 0 3 cafe", ready1, addr1, dqo1); end
    @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wr_done got %b expected 1", ready1); end
    rdEn = 1'b1; address = 32'd1028;
    @(negedge clk);
    checks++; if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_ready got %b expected 0", ready1); end
    @(negedge clk);
    rdEn = 1'b0;
    checks++; if (ready1 !== 1'b0 || addr1 !== 18'd2) begin errors++; $display("[TB] FAIL b2b_rd_lo got rdy=%b addr=%h expected 0 2", ready1, addr1); end
    @(negedge clk);
    checks++; if (ready1 !== 1'b0 || addr1 !== 18'd3) begin errors++; $display("[TB] FAIL b2b_rd_hi got rdy=%b addr=%h expected 0 3", ready1, addr1); end
    @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rd_done got %b expected 1", ready1); end
    checks++; if (rd1 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_readData got %h expected cafef00d", rd1); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem4[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    test_reset;
    test_write;
    test_read(32'd1024, 32'h0);
    test_read(32'd1026, 32'hDEADBEEF);
    test_write_priority;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
